wb_port_arbiter: RTL

Write-back port arbiter for the register file. It shares the single register-file write port between two producers: the ALU result path and the load-return path, each of which supplies a destination address already resolved by the stage-2 destination mux. Each producer gets a 2-entry buffer, heads are granted round-robin, and one registered write per cycle is issued. A combinational pending-write query lets the hazard unit stall readers of registers whose write has not yet been issued.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_fifo2.sv | 89 ++++++++
 rtl/wb_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared types and constants for the write-back port arbiter.
//            Holds default widths, the grant encoding and the buffered
//            entry record.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // Grant encoding, also used for the last-grant history bit.
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo2
// Purpose  : Two-entry FIFO for one write-back producer. Exposes its head
//            for arbitration and every entry's valid/address for the
//            pending-write hazard compare.
// Ports    : clk, rst_n           - clock, synchronous active-low reset
//            push, push_addr/data - enqueue (ignored when full)
//            pop                  - dequeue head (ignored when empty)
//            head_valid/addr/data - oldest entry
//            count                - occupancy 0..2
//            ent_valid, ent_addr  - per-slot valid and packed addresses
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo2
  import wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [ADDR_W-1:0]   push_addr,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic                head_valid,
  output logic [ADDR_W-1:0]   head_addr,
  output logic [DATA_W-1:0]   head_data,
  output logic [1:0]          count,
  output logic [1:0]          ent_valid,
  output logic [2*ADDR_W-1:0] ent_addr
);

  logic [ADDR_W-1:0] r_addr [0:1];
  logic [DATA_W-1:0] r_data [0:1];
  logic [1:0]        r_valid;
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic w_push;
  logic w_pop;

  // Guard against overflow/underflow locally so a misbehaving caller
  // cannot corrupt the pointers.
  assign w_push = push && (r_count != 2'd2);
  assign w_pop  = pop  && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 2'b00;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_addr[0] <= '0;
      r_addr[1] <= '0;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else begin
      // Push and pop never target the same slot: with count 1 the write
      // pointer sits on the free slot.
      if (w_push) begin
        r_addr[r_wptr]  <= push_addr;
        r_data[r_wptr]  <= push_data;
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_valid = (r_count != 2'd0);
  assign head_addr  = r_addr[r_rptr];
  assign head_data  = r_data[r_rptr];
  assign count      = r_count;
  assign ent_valid  = r_valid;
  assign ent_addr   = {r_addr[1], r_addr[0]};

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port between the ALU
//            result path and the load-return path. Each producer has a
//            2-entry buffer; heads are granted round-robin and one
//            registered write is issued per cycle. A combinational query
//            reports whether a write to a given register is still pending.
// Ports    : clk, rst_n                  - clock, sync active-low reset
//            alu_valid/addr/data, alu_ready - ALU producer handshake
//            ld_valid/addr/data,  ld_ready  - load producer handshake
//            rf_we, rf_waddr, rf_wdata   - registered write port
//            hz_addr, hz_hit             - pending-write query
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 2           // buffer is a fixed 2-entry FIFO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] hz_addr,
  output logic              hz_hit
);

  localparam logic [1:0] C_DEPTH = DEPTH[1:0];

  logic                w_alu_hv, w_ld_hv;
  logic [ADDR_W-1:0]   w_alu_haddr, w_ld_haddr;
  logic [DATA_W-1:0]   w_alu_hdata, w_ld_hdata;
  logic [1:0]          w_alu_count, w_ld_count;
  logic [1:0]          w_alu_ent_valid, w_ld_ent_valid;
  logic [2*ADDR_W-1:0] w_alu_ent_addr, w_ld_ent_addr;

  logic                w_gnt_alu, w_gnt_ld, w_conflict;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_hz_match;
  logic                r_last;

  // Ready depends only on stored occupancy, never on valid or grant, so a
  // full buffer that drains this cycle still reports not-ready.
  assign alu_ready = (w_alu_count < C_DEPTH);
  assign ld_ready  = (w_ld_count  < C_DEPTH);

  wb_fifo2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_alu_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (alu_valid && alu_ready),
    .push_addr  (alu_addr),
    .push_data  (alu_data),
    .pop        (w_gnt_alu),
    .head_valid (w_alu_hv),
    .head_addr  (w_alu_haddr),
    .head_data  (w_alu_hdata),
    .count      (w_alu_count),
    .ent_valid  (w_alu_ent_valid),
    .ent_addr   (w_alu_ent_addr)
  );

  wb_fifo2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ld_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ld_valid && ld_ready),
    .push_addr  (ld_addr),
    .push_data  (ld_data),
    .pop        (w_gnt_ld),
    .head_valid (w_ld_hv),
    .head_addr  (w_ld_haddr),
    .head_data  (w_ld_hdata),
    .count      (w_ld_count),
    .ent_valid  (w_ld_ent_valid),
    .ent_addr   (w_ld_ent_addr)
  );

  // Round-robin: a lone head always wins; on a conflict the producer that
  // did not win the previous conflict is granted.
  assign w_conflict = w_alu_hv && w_ld_hv;

  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_ld  = 1'b0;
    if (w_conflict) begin
      if (r_last == GNT_LD) w_gnt_alu = 1'b1;
      else                  w_gnt_ld  = 1'b1;
    end else if (w_alu_hv) begin
      w_gnt_alu = 1'b1;
    end else if (w_ld_hv) begin
      w_gnt_ld = 1'b1;
    end
  end

  assign w_sel_addr = w_gnt_ld ? w_ld_haddr : w_alu_haddr;
  assign w_sel_data = w_gnt_ld ? w_ld_hdata : w_alu_hdata;

  // History only moves on a real conflict, so uncontended traffic from one
  // side does not steal the other side's next turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= GNT_LD;
    end else if (w_conflict) begin
      r_last <= w_gnt_alu ? GNT_ALU : GNT_LD;
    end
  end

  // Output register. A granted write to register 0 is consumed with the
  // enable held low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (w_gnt_alu || w_gnt_ld) begin
      rf_we    <= (w_sel_addr != '0);
      rf_waddr <= w_sel_addr;
      rf_wdata <= w_sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // A write is pending while it sits in either buffer or in the output
  // register with the enable set.
  always_comb begin
    w_hz_match = rf_we && (rf_waddr == hz_addr);
    for (int i = 0; i < 2; i++) begin
      if (w_alu_ent_valid[i] && (w_alu_ent_addr[i*ADDR_W +: ADDR_W] == hz_addr))
        w_hz_match = 1'b1;
      if (w_ld_ent_valid[i] && (w_ld_ent_addr[i*ADDR_W +: ADDR_W] == hz_addr))
        w_hz_match = 1'b1;
    end
  end

  assign hz_hit = (hz_addr != '0) && w_hz_match;

endmodule
`default_nettype wire
